neo_p2_arb: RTL
===============

NEO_P2_ARB -- requirements
Module: neo_p2_arb

Interface
REQ-001: Parameter ADDR_W, default 24, sets the byte-address width of the P2 ROM space.
REQ-002: Parameter MAX_STREAK, default 3, sets the number of consecutive CPU grants allowed while a loader request waits.
REQ-003: Ports SHALL be as follows.
- CLK_24M  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_REQ  in  1  68K P2 read request (level, held until CPU_ACK).
- CPU_ADDR  in  ADDR_W  banked P2 byte address from the SMA bank mapper.
- CPU_DATA  out  16  read data, valid while CPU_ACK is high.
- CPU_ACK  out  1  one-cycle read completion pulse.
- LD_REQ  in  1  ROM-loader write request (level, held until LD_ACK).
- LD_ADDR  in  ADDR_W  loader byte address.
- LD_DATA  in  16  loader write data.
- LD_ACK  out  1  one-cycle write completion pulse.
- SD_REQ  out  1  SDRAM port request, held until SD_RDY.
- SD_WE  out  1  1 = write, 0 = read.
- SD_ADDR  out  ADDR_W  SDRAM byte address; bit 0 forced to 0.
- SD_WDATA  out  16  SDRAM write data.
- SD_RDATA  in  16  SDRAM read data, valid with SD_RDY.
- SD_RDY  in  1  SDRAM completion strobe (one cycle).
REQ-004: One clock; reset is asynchronous and active-high.

Function
REQ-005: The FSM SHALL have exactly four states: IDLE, RD, WR, DONE.
REQ-006: A one-entry read cache SHALL hold VALID, TAG[ADDR_W-1:1] and DATA[15:0].
REQ-007: CPU_ADDR[0] and LD_ADDR[0] SHALL be ignored for compare, tag and SD_ADDR.
REQ-008: In IDLE with CPU_REQ=1 and a cache hit (VALID, TAG==CPU_ADDR[ADDR_W-1:1]) and the CPU selected, the next edge SHALL load CPU_DATA<=DATA, CPU_ACK<=1 and state<=DONE, with no SDRAM access.
REQ-009: In IDLE with a CPU miss selected, the next edge SHALL set SD_REQ=1, SD_WE=0, SD_ADDR=CPU_ADDR and state<=RD.
REQ-010: In IDLE with the loader selected, the next edge SHALL set SD_REQ=1, SD_WE=1, SD_ADDR=LD_ADDR, SD_WDATA=LD_DATA, VALID<=0 and state<=WR.
REQ-011: In RD or WR, SD_REQ, SD_WE, SD_ADDR and SD_WDATA SHALL remain stable until SD_RDY is sampled high.
REQ-012: At the RD edge where SD_RDY=1: SD_REQ<=0, CPU_DATA<=SD_RDATA, CPU_ACK<=1, cache<={1, SD_ADDR[ADDR_W-1:1], SD_RDATA}, state<=DONE.
REQ-013: At the WR edge where SD_RDY=1: SD_REQ<=0, LD_ACK<=1, state<=DONE.
REQ-014: SD_RDY while in IDLE or DONE SHALL be ignored.
REQ-015: DONE SHALL last exactly one cycle, with its ACK high, then go to IDLE; requests are not sampled in DONE.
REQ-016: Requesters deassert REQ in the cycle after ACK; a REQ still high in IDLE is a new request.
REQ-017: Arbitration in IDLE: CPU wins by default. The loader wins when only LD_REQ=1, or when LD_REQ=1 and STREAK==MAX_STREAK.
REQ-018: STREAK (2+ bits, saturating) SHALL update on each grant as follows.
- Increments on each CPU grant (hit or miss) while LD_REQ=1.
- Clears on a loader grant.
- Clears on any IDLE cycle with LD_REQ=0.
REQ-019: CPU_ACK and LD_ACK SHALL never be high in the same cycle.
REQ-020: Latency SHALL be as follows.
- Hit: CPU_ACK one cycle after the request is sampled.
- Miss: SD_REQ one cycle after the request is sampled; CPU_ACK one cycle after SD_RDY.
REQ-021: CPU_DATA SHALL hold its last value between acks.

Reset
REQ-022: While RESET=1, immediately and independent of the clock, all outputs SHALL be 0 and the following state SHALL be cleared.
- state=IDLE, VALID=0, STREAK=0.
- TAG and DATA=0.
REQ-023: Reset asserted during RD or WR SHALL abandon the access: SD_REQ drops asynchronously, no ACK is issued, and a late SD_RDY after release is ignored per REQ-014.
REQ-024: The first request after reset release SHALL be sampled on the first rising edge with RESET=0.

Verification
REQ-025: CPU_REQ, CPU_ADDR=0x200010, SD_RDY returns 0xBEEF 3 cycles after SD_REQ -> SD_WE=0, SD_ADDR=0x200010; CPU_DATA=0xBEEF with a one-cycle CPU_ACK the cycle after SD_RDY.
REQ-026: Repeat the read with CPU_ADDR=0x200011 -> CPU_ACK 1 cycle after the request, CPU_DATA=0xBEEF, SD_REQ stays 0.
REQ-027: LD write 0x1234 to 0x200010, then CPU read of 0x200010 -> cache invalidated; SDRAM read issued (miss), SD_WE=0.
REQ-028: LD_REQ held high with back-to-back CPU_REQ, MAX_STREAK=3 -> grant order CPU, CPU, CPU, LD, CPU...; LD_ACK within 4 grants.
REQ-029: CPU_REQ and LD_REQ rise in the same cycle from reset -> CPU is served first, then LD; ACKs are never coincident.
REQ-030: RESET pulsed 2 cycles after SD_REQ in RD, SD_RDY arriving after release -> SD_REQ low during reset, no CPU_ACK, VALID=0, FSM in IDLE.

Source files
------------

// File: rtl/neo_p2_arb_if.sv
// P2 ROM port bundle: 68K read port, ROM-loader write port and the shared SDRAM port.
// The arbiter takes the slave view; the requesters/SDRAM side take the master view.
interface neo_p2_arb_if #(
  parameter int ADDR_W = 24
);
  logic              CPU_REQ;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [15:0]       CPU_DATA;
  logic              CPU_ACK;
  logic              LD_REQ;
  logic [ADDR_W-1:0] LD_ADDR;
  logic [15:0]       LD_DATA;
  logic              LD_ACK;
  logic              SD_REQ;
  logic              SD_WE;
  logic [ADDR_W-1:0] SD_ADDR;
  logic [15:0]       SD_WDATA;
  logic [15:0]       SD_RDATA;
  logic              SD_RDY;

  modport slave (
    input  CPU_REQ, CPU_ADDR, LD_REQ, LD_ADDR, LD_DATA, SD_RDATA, SD_RDY,
    output CPU_DATA, CPU_ACK, LD_ACK, SD_REQ, SD_WE, SD_ADDR, SD_WDATA
  );

  modport master (
    output CPU_REQ, CPU_ADDR, LD_REQ, LD_ADDR, LD_DATA, SD_RDATA, SD_RDY,
    input  CPU_DATA, CPU_ACK, LD_ACK, SD_REQ, SD_WE, SD_ADDR, SD_WDATA
  );
endinterface

// File: rtl/neo_p2_arb.sv
// P2 ROM arbiter: shares one SDRAM port between 68K reads (with a one-word read cache)
// and ROM-loader writes, bounding how long the loader can be starved by the CPU.
module neo_p2_arb #(
  parameter int ADDR_W     = 24,
  parameter int MAX_STREAK = 3
) (
  input  logic          CLK_24M,
  input  logic          RESET,
  neo_p2_arb_if.slave   bus
);

  localparam int SW = ($clog2(MAX_STREAK + 1) < 2) ? 2 : $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state, state_nxt;
  logic                valid, valid_nxt;
  logic [ADDR_W-2:0]   tag, tag_nxt;
  logic [15:0]         data, data_nxt;
  logic [SW-1:0]       streak, streak_nxt;
  logic                sd_req, sd_req_nxt;
  logic                sd_we, sd_we_nxt;
  logic [ADDR_W-1:0]   sd_addr, sd_addr_nxt;
  logic [15:0]         sd_wdata, sd_wdata_nxt;
  logic [15:0]         cpu_data, cpu_data_nxt;
  logic                cpu_ack, cpu_ack_nxt;
  logic                ld_ack, ld_ack_nxt;
  logic                hit, ld_sel, cpu_sel;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    if (s >= SW'(MAX_STREAK)) return SW'(MAX_STREAK);
    return s + SW'(1);
  endfunction

  // Byte address bit 0 never matters: the ROM is word-organised.
  assign hit     = valid && (tag == bus.CPU_ADDR[ADDR_W-1:1]);
  assign ld_sel  = bus.LD_REQ && (!bus.CPU_REQ || (streak == SW'(MAX_STREAK)));
  assign cpu_sel = bus.CPU_REQ && !ld_sel;

  always_comb begin
    state_nxt    = state;
    valid_nxt    = valid;
    tag_nxt      = tag;
    data_nxt     = data;
    streak_nxt   = streak;
    sd_req_nxt   = sd_req;
    sd_we_nxt    = sd_we;
    sd_addr_nxt  = sd_addr;
    sd_wdata_nxt = sd_wdata;
    cpu_data_nxt = cpu_data;
    cpu_ack_nxt  = 1'b0;
    ld_ack_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.LD_REQ) streak_nxt = '0;
        if (ld_sel) begin
          sd_req_nxt   = 1'b1;
          sd_we_nxt    = 1'b1;
          sd_addr_nxt  = {bus.LD_ADDR[ADDR_W-1:1], 1'b0};
          sd_wdata_nxt = bus.LD_DATA;
          valid_nxt    = 1'b0;
          streak_nxt   = '0;
          state_nxt    = WR;
        end else if (cpu_sel) begin
          if (bus.LD_REQ) streak_nxt = streak_inc(streak);
          if (hit) begin
            cpu_data_nxt = data;
            cpu_ack_nxt  = 1'b1;
            state_nxt    = DONE;
          end else begin
            sd_req_nxt  = 1'b1;
            sd_we_nxt   = 1'b0;
            sd_addr_nxt = {bus.CPU_ADDR[ADDR_W-1:1], 1'b0};
            state_nxt   = RD;
          end
        end
      end
      RD: begin
        if (bus.SD_RDY) begin
          sd_req_nxt   = 1'b0;
          cpu_data_nxt = bus.SD_RDATA;
          cpu_ack_nxt  = 1'b1;
          valid_nxt    = 1'b1;
          tag_nxt      = sd_addr[ADDR_W-1:1];
          data_nxt     = bus.SD_RDATA;
          state_nxt    = DONE;
        end
      end
      WR: begin
        if (bus.SD_RDY) begin
          sd_req_nxt = 1'b0;
          ld_ack_nxt = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset abandons any SDRAM access in flight and empties the cache.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      valid    <= 1'b0;
      tag      <= '0;
      data     <= '0;
      streak   <= '0;
      sd_req   <= 1'b0;
      sd_we    <= 1'b0;
      sd_addr  <= '0;
      sd_wdata <= '0;
      cpu_data <= '0;
      cpu_ack  <= 1'b0;
      ld_ack   <= 1'b0;
    end else begin
      state    <= state_nxt;
      valid    <= valid_nxt;
      tag      <= tag_nxt;
      data     <= data_nxt;
      streak   <= streak_nxt;
      sd_req   <= sd_req_nxt;
      sd_we    <= sd_we_nxt;
      sd_addr  <= sd_addr_nxt;
      sd_wdata <= sd_wdata_nxt;
      cpu_data <= cpu_data_nxt;
      cpu_ack  <= cpu_ack_nxt;
      ld_ack   <= ld_ack_nxt;
    end
  end

  assign bus.CPU_DATA = cpu_data;
  assign bus.CPU_ACK  = cpu_ack;
  assign bus.LD_ACK   = ld_ack;
  assign bus.SD_REQ   = sd_req;
  assign bus.SD_WE    = sd_we;
  assign bus.SD_ADDR  = sd_addr;
  assign bus.SD_WDATA = sd_wdata;

endmodule
